dmem_ctrl: RTL
==============

// Module: dmem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of the MEM stage. Accepts MEM's memCe/memWr/memAddr/wtData
//  strobes, runs a fixed-latency multi-cycle access to an on-board synchronous SRAM and returns rdData.
//  Holds the LL/SC reservation (LLbit + reserved address) and produces rLLbit for MEM.
//  Asserts stall to freeze PC and the upstream stages while an access is in flight.
// PARAMETERS
//  ADDR_W       10  SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
//  WAIT_CYCLES  2   extra SRAM wait states (>=0); sets the ACCESS-state length.
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       reset, synchronous, active-high
//  memCe       in   1       access request from MEM
//  memWr       in   1       1=store, 0=load (valid with memCe)
//  memAddr     in   32      byte address
//  wtData      in   32      store data
//  wbit        in   1       LLbit write enable (ll/sc)
//  wLLbit      in   1       new LLbit value
//  llclr       in   1       clear reservation (exception/eret)
//  rdData      out  32      load data, valid in DONE
//  rLLbit      out  1       current LLbit
//  stall       out  1       freeze pipeline
//  sram_ce     out  1       SRAM chip enable
//  sram_we     out  1       SRAM write enable
//  sram_addr   out  ADDR_W  SRAM word address
//  sram_wdata  out  32      SRAM write data
//  sram_rdata  in   32      SRAM read data (registered by SRAM, valid 1 cycle after addr)
//  misalign    out  1       alignment fault (only with DMEM_ALIGN_CHK_EN)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rdData=0, rLLbit=0, lladdr=0, sram_ce=0, sram_we=0, misalign=0; stall=0 while rst=1.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: memCe=1 -> latch addr/wdata/we, cnt<=WAIT_CYCLES, go ACCESS; stall=1 (combinational).
//         memCe=0 -> stall=0; if wbit=1, LLbit update applied at this edge (failed sc, no memory access).
//   ACCESS: sram_ce=1, sram_addr=latched addr[ADDR_W+1:2], sram_we=latched we, sram_wdata=latched data;
//         stall=1; cnt decrements; at cnt==0 capture sram_rdata into rdData (loads), go DONE.
//   DONE: sram_ce=0, sram_we=0, stall=0 (pipeline advances at this edge); commit LL update; go IDLE
//         unconditionally (memCe still high in DONE never re-triggers).
//  Latency: stall high for WAIT_CYCLES+2 cycles; rdData valid in DONE cycle (WAIT_CYCLES+2 after request).
//  rdData holds last load value until the next load completes; stores leave it unchanged.
//  LL update priority (highest first), applied at the edge leaving DONE (or IDLE for memCe=0):
//   1 llclr=1 -> LLbit<=0 (any state, any cycle)
//   2 wbit=1  -> LLbit<=wLLbit; if wLLbit=1 also lladdr<=addr[31:2]
//   3 store committed with addr[31:2]==lladdr -> LLbit<=0
//  rLLbit stable throughout ACCESS so MEM's sc decision cannot change mid-access.
//  rst asserted mid-ACCESS: next edge -> IDLE, sram_we/sram_ce deassert; partial store not retried.
//  Back-to-back requests: new request accepted in the IDLE cycle after DONE (one bubble minimum).
// CONFIGURATION
//  DMEM_ALIGN_CHK_EN defined: request with memAddr[1:0]!=0 skips ACCESS (sram_ce stays 0), goes straight to
//   DONE next cycle with misalign=1 for that DONE cycle only; rdData unchanged; no LL update except llclr.
//  Not defined: memAddr[1:0] ignored, misalign tied 0, all requests take the full path.
// TESTING (WAIT_CYCLES=2)
//  sw 0xDEADBEEF @0x40, then lw @0x40 -> stall high 4 cycles each, sram_we=1 only in store ACCESS, rdData=0xDEADBEEF in DONE.
//  ll @0x80 (wbit=1,wLLbit=1) -> rLLbit=1 after DONE; sc @0x80 (wLLbit=0) -> store writes, rLLbit=0 after DONE.
//  ll @0x80 then sw @0x80 -> rLLbit cleared after sw DONE; sw @0x84 instead -> rLLbit stays 1.
//  rLLbit=1, llclr=1 pulse during ACCESS of unrelated lw -> rLLbit=0 next cycle, lw still returns correct data.
//  rst asserted in 2nd ACCESS cycle of store -> IDLE next cycle, stall=0, sram_we=0, rdData=0, rLLbit=0.
//  DMEM_ALIGN_CHK_EN: lw @0x42 -> stall 1 cycle, misalign=1 in DONE, sram_ce never asserted, rdData unchanged.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory controller sitting behind the MEM stage.
//
// Turns a single-cycle memCe/memWr request into a fixed-length access to a
// synchronous SRAM. The LL/SC reservation (LLbit plus reserved word address)
// is kept here, and stall freezes the pipeline while an access is in flight.
//
// Optional feature macro: DMEM_ALIGN_CHK_EN. When it is defined, a request with
// memAddr[1:0] != 0 skips the SRAM, goes directly to DONE and pulses misalign.
// When it is undefined, the low address bits are ignored and misalign is tied 0.
//
// Ports:
//   clk, rst           rising-edge clock and synchronous active-high reset
//   memCe, memWr       request strobe and store/load select from MEM
//   memAddr, wtData    byte address and store data
//   wbit, wLLbit       LLbit write enable and new value (ll/sc)
//   llclr              drop the reservation (exception/eret)
//   rdData             load data, valid in DONE and held until the next load
//   rLLbit             current LLbit
//   stall              freeze PC and the upstream stages
//   sram_*             SRAM control, address, write data and read data
//   misalign           alignment fault, high for one DONE cycle
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memCe,
  input  logic              memWr,
  input  logic [31:0]       memAddr,
  input  logic [31:0]       wtData,
  input  logic              wbit,
  input  logic              wLLbit,
  input  logic              llclr,
  output logic [31:0]       rdData,
  output logic              rLLbit,
  output logic              stall,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              misalign
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [29:0]        addr_q, addr_d;     // latched byte address [31:2]
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        rd_q, rd_d;
  logic               llbit_q, llbit_d;
  logic [29:0]        lladdr_q, lladdr_d;
  logic               mis_q, mis_d;

  logic               req_misaligned;
  logic               ll_commit;
  logic               ll_store;
  logic [29:0]        ll_addr_src;

`ifdef DMEM_ALIGN_CHK_EN
  assign req_misaligned = (memAddr[1:0] != 2'b00);
  assign misalign       = mis_q;
`else
  logic unused_low_addr;
  assign unused_low_addr = ^memAddr[1:0];
  assign req_misaligned  = 1'b0;
  assign misalign        = 1'b0;
`endif

  assign rdData     = rd_q;
  assign rLLbit     = llbit_q;
  assign sram_addr  = addr_q[ADDR_W-1:0];
  assign sram_wdata = wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    rd_d        = rd_q;
    mis_d       = 1'b0;
    stall       = 1'b0;
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    ll_commit   = 1'b0;
    ll_store    = 1'b0;
    ll_addr_src = addr_q;

    case (state_q)
      S_IDLE: begin
        if (memCe) begin
          stall   = 1'b1;
          addr_d  = memAddr[31:2];
          wdata_d = wtData;
          we_d    = memWr;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          if (req_misaligned) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          // No access: an ll/sc-only update (failed sc) lands at this edge.
          ll_commit   = 1'b1;
          ll_addr_src = memAddr[31:2];
        end
      end
      S_ACCESS: begin
        stall   = 1'b1;
        sram_ce = 1'b1;
        sram_we = we_q;
        if (cnt_q == '0) begin
          if (!we_q) rd_d = sram_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        // Always return to IDLE so a memCe still held high cannot re-trigger.
        state_d   = S_IDLE;
        ll_commit = !mis_q;
        ll_store  = we_q;
      end
      default: state_d = S_IDLE;
    endcase

    llbit_d  = llbit_q;
    lladdr_d = lladdr_q;
    if (llclr) begin
      llbit_d = 1'b0;
    end else if (ll_commit) begin
      if (wbit) begin
        llbit_d = wLLbit;
        if (wLLbit) lladdr_d = ll_addr_src;
      end else if (ll_store && (addr_q == lladdr_q)) begin
        llbit_d = 1'b0;
      end
    end

    // Reset cycle: release the pipeline and abort any SRAM cycle in progress.
    if (rst) begin
      stall   = 1'b0;
      sram_ce = 1'b0;
      sram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      llbit_q  <= 1'b0;
      lladdr_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      llbit_q  <= llbit_d;
      lladdr_q <= lladdr_d;
      mis_q    <= mis_d;
    end
  end

endmodule
